vortex_axil_ctrl_responder: RTL and testbench

AXI4-Lite slave (responder) that terminates the control-port AXI4-Lite master in the NoC bridge. It implements the Vortex control/status register bank: start/done/idle handshake, interrupt enable/status, read-only device capabilities, and DCR write forwarding. It sits between the bridge's AXI4-Lite master and the Vortex core's start/DCR/done signals. It is the register-side counterpart used for bring-up and for the AFU control path.

---
 rtl/vortex_ctrl_pkg.sv | 27 ++
 rtl/vortex_axil_ctrl_responder_if.sv | 33 +++
 rtl/vortex_axil_wr_capture.sv | 60 ++++++
 rtl/vortex_axil_ctrl_responder.sv | 218 +++++++++++++++++++++
 tb/tb_vortex_axil_ctrl_responder.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vortex_ctrl_pkg.sv
// Shared definitions for the Vortex AXI4-Lite control responder:
// register word selects, response codes and CTRL bit positions.
package vortex_ctrl_pkg;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_GIE      = 3'd1,
        REG_IER      = 3'd2,
        REG_ISR      = 3'd3,
        REG_CAPS_LO  = 3'd4,
        REG_CAPS_HI  = 3'd5,
        REG_DCR_ADDR = 3'd6,
        REG_DCR_DATA = 3'd7
    } reg_sel_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_DONE_BIT  = 1;
    localparam int CTRL_IDLE_BIT  = 2;

    function automatic logic [1:0] reg_resp(input logic mapped);
        return mapped ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/vortex_axil_ctrl_responder_if.sv
// AXI4-Lite control-port bundle between the bridge master and the responder.
interface vortex_axil_ctrl_responder_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/vortex_axil_wr_capture.sv
// One-entry AW and W holding registers; commit fires while both are held
// and clears them, so a write costs handshake, commit and response cycles.
module vortex_axil_wr_capture #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    i_en,
    input  logic                    i_bvalid,
    input  logic                    i_awvalid,
    input  logic [ADDR_WIDTH-3:0]   i_awaddr,
    input  logic                    i_wvalid,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    output logic                    o_awready,
    output logic                    o_wready,
    output logic                    o_commit,
    output logic [ADDR_WIDTH-3:0]   o_addr,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [DATA_WIDTH/8-1:0] o_strb
);
    logic                    r_aw_held;
    logic                    r_w_held;
    logic [ADDR_WIDTH-3:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH/8-1:0] r_strb;

    assign o_awready = i_en && !r_aw_held && !i_bvalid;
    assign o_wready  = i_en && !r_w_held && !i_bvalid;
    assign o_commit  = r_aw_held && r_w_held;
    assign o_addr    = r_addr;
    assign o_data    = r_data;
    assign o_strb    = r_strb;

    // Capture address and data independently; both clear on commit.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_strb    <= '0;
        end else begin
            if (o_commit) begin
                r_aw_held <= 1'b0;
            end else if (i_awvalid && o_awready) begin
                r_aw_held <= 1'b1;
                r_addr    <= i_awaddr;
            end
            if (o_commit) begin
                r_w_held <= 1'b0;
            end else if (i_wvalid && o_wready) begin
                r_w_held <= 1'b1;
                r_data   <= i_wdata;
                r_strb   <= i_wstrb;
            end
        end
    end
endmodule

// File: rtl/vortex_axil_ctrl_responder.sv
// Vortex control/status register bank behind an AXI4-Lite responder:
// start/done/idle, interrupt enable/status, capabilities and DCR forwarding.
module vortex_axil_ctrl_responder
    import vortex_ctrl_pkg::*;
#(
    parameter int          C_S_AXI_CTRL_ADDR_WIDTH = 8,
    parameter int          C_S_AXI_CTRL_DATA_WIDTH = 32,
    parameter int          DCR_ADDR_WIDTH          = 12,
    parameter logic [63:0] DEV_CAPS                = 64'h0
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst_n,
    vortex_axil_ctrl_responder_if.slave        s_axi_ctrl,
    output logic                               ap_start,
    input  logic                               ap_done,
    input  logic                               ap_idle,
    output logic                               dcr_wr_valid,
    output logic [DCR_ADDR_WIDTH-1:0]          dcr_wr_addr,
    output logic [C_S_AXI_CTRL_DATA_WIDTH-1:0] dcr_wr_data,
    output logic                               interrupt
);
    localparam int AW = C_S_AXI_CTRL_ADDR_WIDTH;
    localparam int DW = C_S_AXI_CTRL_DATA_WIDTH;
    localparam int SW = DW / 8;

    logic                      r_live;
    logic                      r_ap_start, r_done_sticky, r_gie, r_ier, r_isr, r_interrupt;
    logic [DCR_ADDR_WIDTH-1:0] r_dcr_addr, r_dcr_wr_addr;
    logic [DW-1:0]             r_dcr_wr_data, r_rdata;
    logic                      r_dcr_wr_valid, r_bvalid, r_rvalid;
    logic [1:0]                r_bresp, r_rresp;

    logic                      w_commit, w_awready, w_wready;
    logic [AW-3:0]             w_wr_addr;
    logic [DW-1:0]             w_wr_data, w_rdata;
    logic [SW-1:0]             w_wr_strb;
    logic                      w_wr_mapped, w_ar_mapped, w_ar_hs;
    reg_sel_e                  w_wr_sel, w_ar_sel;
    logic                      w_wr_ctrl, w_wr_gie, w_wr_ier, w_wr_isr, w_wr_dcra, w_wr_dcrd;
    logic [DCR_ADDR_WIDTH-1:0] w_dcr_addr_nxt;
    logic                      w_unused;

    vortex_axil_wr_capture #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_wr_capture (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .i_en      (r_live),
        .i_bvalid  (r_bvalid),
        .i_awvalid (s_axi_ctrl.awvalid),
        .i_awaddr  (s_axi_ctrl.awaddr[AW-1:2]),
        .i_wvalid  (s_axi_ctrl.wvalid),
        .i_wdata   (s_axi_ctrl.wdata),
        .i_wstrb   (s_axi_ctrl.wstrb),
        .o_awready (w_awready),
        .o_wready  (w_wready),
        .o_commit  (w_commit),
        .o_addr    (w_wr_addr),
        .o_data    (w_wr_data),
        .o_strb    (w_wr_strb)
    );

    assign w_wr_mapped = ~|w_wr_addr[AW-3:3];
    assign w_wr_sel    = reg_sel_e'(w_wr_addr[2:0]);
    assign w_ar_mapped = ~|s_axi_ctrl.araddr[AW-1:5];
    assign w_ar_sel    = reg_sel_e'(s_axi_ctrl.araddr[4:2]);
    assign w_ar_hs     = s_axi_ctrl.arvalid && s_axi_ctrl.arready;
    assign w_unused    = ^{s_axi_ctrl.awaddr[1:0], s_axi_ctrl.araddr[1:0], w_wr_strb[SW-1:2]};

    assign s_axi_ctrl.awready = w_awready;
    assign s_axi_ctrl.wready  = w_wready;
    assign s_axi_ctrl.bvalid  = r_bvalid;
    assign s_axi_ctrl.bresp   = r_bresp;
    assign s_axi_ctrl.arready = r_live && !r_rvalid;
    assign s_axi_ctrl.rvalid  = r_rvalid;
    assign s_axi_ctrl.rdata   = r_rdata;
    assign s_axi_ctrl.rresp   = r_rresp;
    assign ap_start           = r_ap_start;
    assign interrupt          = r_interrupt;
    assign dcr_wr_valid       = r_dcr_wr_valid;
    assign dcr_wr_addr        = r_dcr_wr_addr;
    assign dcr_wr_data        = r_dcr_wr_data;

    // Decode the committed write into per-register strobes.
    always_comb begin
        w_wr_ctrl = 1'b0;
        w_wr_gie  = 1'b0;
        w_wr_ier  = 1'b0;
        w_wr_isr  = 1'b0;
        w_wr_dcra = 1'b0;
        w_wr_dcrd = 1'b0;
        if (w_commit && w_wr_mapped) begin
            case (w_wr_sel)
                REG_CTRL:     w_wr_ctrl = 1'b1;
                REG_GIE:      w_wr_gie  = 1'b1;
                REG_IER:      w_wr_ier  = 1'b1;
                REG_ISR:      w_wr_isr  = 1'b1;
                REG_DCR_ADDR: w_wr_dcra = 1'b1;
                REG_DCR_DATA: w_wr_dcrd = 1'b1;
                default:      w_wr_ctrl = 1'b0;
            endcase
        end else begin
            w_wr_ctrl = 1'b0;
        end
    end

    // Byte-enable merge for DCR_ADDR.
    always_comb begin
        w_dcr_addr_nxt = r_dcr_addr;
        for (int i = 0; i < DCR_ADDR_WIDTH; i++) begin
            if (w_wr_strb[i/8]) begin
                w_dcr_addr_nxt[i] = w_wr_data[i];
            end else begin
                w_dcr_addr_nxt[i] = r_dcr_addr[i];
            end
        end
    end

    // Read data mux; always sees register state before any same-cycle update.
    always_comb begin
        w_rdata = '0;
        if (w_ar_mapped) begin
            case (w_ar_sel)
                REG_CTRL: begin
                    w_rdata[CTRL_START_BIT] = r_ap_start;
                    w_rdata[CTRL_DONE_BIT]  = r_done_sticky;
                    w_rdata[CTRL_IDLE_BIT]  = ap_idle;
                end
                REG_GIE:      w_rdata[0] = r_gie;
                REG_IER:      w_rdata[0] = r_ier;
                REG_ISR:      w_rdata[0] = r_isr;
                REG_CAPS_LO:  w_rdata = DEV_CAPS[31:0];
                REG_CAPS_HI:  w_rdata = DEV_CAPS[63:32];
                REG_DCR_ADDR: w_rdata[DCR_ADDR_WIDTH-1:0] = r_dcr_addr;
                default:      w_rdata = '0;
            endcase
        end else begin
            w_rdata = '0;
        end
    end

    // Ready outputs stay low until the first clock after reset release.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_live <= 1'b0;
        else           r_live <= 1'b1;
    end

    // Register bank: ap_done wins over every same-cycle write or read-clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_ap_start    <= 1'b0;
            r_done_sticky <= 1'b0;
            r_gie         <= 1'b0;
            r_ier         <= 1'b0;
            r_isr         <= 1'b0;
            r_dcr_addr    <= '0;
            r_interrupt   <= 1'b0;
        end else begin
            if (ap_done)
                r_ap_start <= 1'b0;
            else if (w_wr_ctrl && w_wr_strb[0] && w_wr_data[CTRL_START_BIT])
                r_ap_start <= 1'b1;
            if (ap_done)
                r_done_sticky <= 1'b1;
            else if (w_ar_hs && w_ar_mapped && (w_ar_sel == REG_CTRL))
                r_done_sticky <= 1'b0;
            if (w_wr_gie && w_wr_strb[0]) r_gie <= w_wr_data[0];
            if (w_wr_ier && w_wr_strb[0]) r_ier <= w_wr_data[0];
            if (ap_done && r_ier)
                r_isr <= 1'b1;
            else if (w_wr_isr && w_wr_strb[0] && w_wr_data[0])
                r_isr <= 1'b0;
            if (w_wr_dcra) r_dcr_addr <= w_dcr_addr_nxt;
            r_interrupt <= r_gie & r_ier & r_isr;
        end
    end

    // DCR write forwarding: one-cycle strobe, address/data held until the next one.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_dcr_wr_valid <= 1'b0;
            r_dcr_wr_addr  <= '0;
            r_dcr_wr_data  <= '0;
        end else begin
            r_dcr_wr_valid <= w_wr_dcrd;
            if (w_wr_dcrd) begin
                r_dcr_wr_addr <= r_dcr_addr;
                r_dcr_wr_data <= w_wr_data;
            end
        end
    end

    // Write response channel.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= reg_resp(w_wr_mapped);
        end else if (r_bvalid && s_axi_ctrl.bready) begin
            r_bvalid <= 1'b0;
        end
    end

    // Read response channel; data held stable until accepted.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= 2'b00;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdata;
            r_rresp  <= reg_resp(w_ar_mapped);
        end else if (r_rvalid && s_axi_ctrl.rready) begin
            r_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vortex_axil_ctrl_responder.sv
// Scoreboard bench for vortex_axil_ctrl_responder: stimulus pushes expected
// B/R/DCR responses, negedge monitors pop and compare on each DUT output.
module tb_vortex_axil_ctrl_responder;
    import vortex_ctrl_pkg::*;

    localparam logic [63:0] CAPS = 64'h1234_5678_9ABC_DEF0;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start, ap_done, ap_idle;
    logic        dcr_wr_valid, interrupt;
    logic [11:0] dcr_wr_addr;
    logic [31:0] dcr_wr_data;

    int n_pass  = 0;
    int n_total = 0;

    logic [1:0]  exp_b[$];
    rexp_t       exp_r[$];
    logic [43:0] exp_dcr[$];

    vortex_axil_ctrl_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) axi ();

    vortex_axil_ctrl_responder #(
        .C_S_AXI_CTRL_ADDR_WIDTH(8),
        .C_S_AXI_CTRL_DATA_WIDTH(32),
        .DCR_ADDR_WIDTH(12),
        .DEV_CAPS(CAPS)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .s_axi_ctrl   (axi),
        .ap_start     (ap_start),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .dcr_wr_valid (dcr_wr_valid),
        .dcr_wr_addr  (dcr_wr_addr),
        .dcr_wr_data  (dcr_wr_data),
        .interrupt    (interrupt)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_aw(input logic [7:0] addr);
        int n;
        n = 0;
        axi.awaddr  = addr;
        axi.awvalid = 1'b1;
        @(negedge ap_clk);
        while (!axi.awready && n < 40) begin
            @(negedge ap_clk);
            n++;
        end
        if (!axi.awready) fail_now("aw_handshake_timeout");
        tick();
        axi.awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb);
        int n;
        n = 0;
        axi.wdata  = data;
        axi.wstrb  = strb;
        axi.wvalid = 1'b1;
        @(negedge ap_clk);
        while (!axi.wready && n < 40) begin
            @(negedge ap_clk);
            n++;
        end
        if (!axi.wready) fail_now("w_handshake_timeout");
        tick();
        axi.wvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [7:0] addr);
        int n;
        n = 0;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        @(negedge ap_clk);
        while (!axi.arready && n < 40) begin
            @(negedge ap_clk);
            n++;
        end
        if (!axi.arready) fail_now("ar_handshake_timeout");
        tick();
        axi.arvalid = 1'b0;
    endtask

    // After the W handshake edge: commit cycle (bvalid low), then bvalid high.
    task automatic finish_b(input logic done_in_commit);
        logic b0, b1;
        int   n;
        ap_done = done_in_commit;
        @(negedge ap_clk);
        b0 = axi.bvalid;
        tick();
        ap_done = 1'b0;
        @(negedge ap_clk);
        b1 = axi.bvalid;
        check("b_timing", {b0, b1}, 2'b01);
        n = 0;
        while (!axi.bvalid && n < 40) begin
            @(negedge ap_clk);
            n++;
        end
        tick();
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int gap, input logic [1:0] resp, input logic done_in_commit);
        exp_b.push_back(resp);
        do_aw(addr);
        repeat (gap) tick();
        do_w(data, strb);
        finish_b(done_in_commit);
    endtask

    task automatic wait_r();
        int n;
        n = 0;
        while (exp_r.size() != 0 && n < 40) begin
            @(negedge ap_clk);
            n++;
        end
        if (exp_r.size() != 0) begin
            fail_now("r_response_timeout");
            exp_r.delete();
        end
        tick();
    endtask

    task automatic axi_read(input string name, input logic [7:0] addr, input logic [31:0] data,
                            input logic [1:0] resp);
        rexp_t e;
        e.name = name;
        e.data = data;
        e.resp = resp;
        exp_r.push_back(e);
        do_ar(addr);
        wait_r();
    endtask

    // B monitor
    initial forever begin
        @(negedge ap_clk);
        if (axi.bvalid && axi.bready) begin
            if (exp_b.size() == 0) fail_now("b_unexpected");
            else check("bresp", {62'd0, axi.bresp}, {62'd0, exp_b.pop_front()});
        end
    end

    // R monitor
    initial forever begin
        rexp_t e;
        @(negedge ap_clk);
        if (axi.rvalid && axi.rready) begin
            if (exp_r.size() == 0) begin
                fail_now("r_unexpected");
            end else begin
                e = exp_r.pop_front();
                check(e.name, {30'd0, axi.rresp, axi.rdata}, {30'd0, e.resp, e.data});
            end
        end
    end

    // DCR monitor
    initial forever begin
        @(negedge ap_clk);
        if (dcr_wr_valid) begin
            if (exp_dcr.size() == 0) fail_now("dcr_unexpected");
            else check("dcr_write", {20'd0, dcr_wr_addr, dcr_wr_data}, {20'd0, exp_dcr.pop_front()});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time bound exceeded");
        $fatal(1);
    end

    initial begin
        ap_rst_n    = 1'b0;
        ap_done     = 1'b0;
        ap_idle     = 1'b0;
        axi.awvalid = 1'b0;
        axi.awaddr  = 8'h00;
        axi.wvalid  = 1'b0;
        axi.wdata   = 32'h0;
        axi.wstrb   = 4'h0;
        axi.bready  = 1'b1;
        axi.arvalid = 1'b0;
        axi.araddr  = 8'h00;
        axi.rready  = 1'b1;

        // Reset state
        repeat (2) @(negedge ap_clk);
        check("reset_outputs",
              {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, axi.bresp, axi.rresp,
               axi.rdata, ap_start, interrupt, dcr_wr_valid}, 64'd0);
        tick();
        ap_rst_n = 1'b1;
        tick();
        @(negedge ap_clk);
        check("readies_after_reset", {axi.awready, axi.wready, axi.arready}, 3'b111);
        tick();

        // Start with AW two cycles ahead of W
        axi_write(8'h00, 32'h1, 4'hF, 2, RESP_OKAY, 1'b0);
        @(negedge ap_clk);
        check("ap_start_set", ap_start, 1'b1);
        tick();
        axi_read("ctrl_running", 8'h00, 32'h1, RESP_OKAY);

        // Interrupt path
        axi_write(8'h04, 32'h1, 4'hF, 0, RESP_OKAY, 1'b0);
        axi_write(8'h08, 32'h1, 4'hF, 0, RESP_OKAY, 1'b0);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        @(negedge ap_clk);
        check("start_cleared_by_done", ap_start, 1'b0);
        check("irq_not_yet", interrupt, 1'b0);
        @(negedge ap_clk);
        check("irq_raised", interrupt, 1'b1);
        tick();
        axi_read("ctrl_done_sticky", 8'h00, 32'h2, RESP_OKAY);
        axi_read("ctrl_cleared_on_read", 8'h00, 32'h0, RESP_OKAY);
        axi_write(8'h0C, 32'h1, 4'hF, 0, RESP_OKAY, 1'b0);
        @(negedge ap_clk);
        check("irq_cleared", interrupt, 1'b0);
        tick();
        axi_read("isr_cleared", 8'h0C, 32'h0, RESP_OKAY);

        // DCR forwarding
        axi_write(8'h18, 32'h0000_0005, 4'hF, 0, RESP_OKAY, 1'b0);
        exp_dcr.push_back({12'h005, 32'hDEAD_BEEF});
        axi_write(8'h1C, 32'hDEAD_BEEF, 4'h0, 1, RESP_OKAY, 1'b0);
        axi_write(8'h18, 32'hFFFF_FFFF, 4'h1, 0, RESP_OKAY, 1'b0);
        axi_read("dcr_addr_bytemask", 8'h18, 32'h0000_00FF, RESP_OKAY);
        axi_read("dcr_data_reads_zero", 8'h1C, 32'h0, RESP_OKAY);
        @(negedge ap_clk);
        check("dcr_outputs_held", {dcr_wr_valid, dcr_wr_addr, dcr_wr_data}, {1'b0, 12'h005, 32'hDEAD_BEEF});
        tick();

        // Unmapped and read-only offsets
        axi_read("unmapped_read", 8'h40, 32'h0, RESP_SLVERR);
        axi_write(8'h44, 32'h0, 4'hF, 0, RESP_SLVERR, 1'b0);
        axi_read("gie_unchanged", 8'h04, 32'h1, RESP_OKAY);
        axi_write(8'h10, 32'hFFFF_FFFF, 4'hF, 0, RESP_OKAY, 1'b0);
        axi_read("caps_lo", 8'h10, CAPS[31:0], RESP_OKAY);
        axi_read("caps_hi", 8'h14, CAPS[63:32], RESP_OKAY);

        // Back-pressure on B blocks new writes
        axi.bready = 1'b0;
        axi_write(8'h04, 32'h1, 4'hF, 0, RESP_OKAY, 1'b0);
        exp_b.push_back(RESP_OKAY);
        axi.awaddr  = 8'h08;
        axi.awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            check("b_stall", {axi.bvalid, axi.awready, axi.wready}, 3'b100);
        end
        tick();
        axi.bready = 1'b1;
        do_aw(8'h08);
        check("aw_after_b_handshake", exp_b.size(), 1);
        do_w(32'h1, 4'hF);
        finish_b(1'b0);

        // ISR W1C colliding with ap_done: set wins
        axi_write(8'h0C, 32'h1, 4'hF, 0, RESP_OKAY, 1'b1);
        axi_read("isr_set_wins", 8'h0C, 32'h1, RESP_OKAY);
        @(negedge ap_clk);
        check("irq_after_collision", interrupt, 1'b1);
        tick();
        axi_read("ctrl_after_collision", 8'h00, 32'h2, RESP_OKAY);

        // CTRL read colliding with ap_done
        ap_idle = 1'b1;
        axi_write(8'h00, 32'h1, 4'hF, 0, RESP_OKAY, 1'b0);
        begin
            rexp_t e;
            e.name = "ctrl_read_with_done";
            e.data = 32'h5;
            e.resp = RESP_OKAY;
            exp_r.push_back(e);
        end
        axi.araddr  = 8'h00;
        axi.arvalid = 1'b1;
        ap_done     = 1'b1;
        tick();
        axi.arvalid = 1'b0;
        ap_done     = 1'b0;
        wait_r();
        axi_read("ctrl_done_after_collision", 8'h00, 32'h6, RESP_OKAY);

        // Reset while a read response is pending
        axi.rready = 1'b0;
        do_ar(8'h04);
        @(negedge ap_clk);
        check("rvalid_held", axi.rvalid, 1'b1);
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("reset_drops_outputs",
              {axi.rvalid, axi.bvalid, axi.arready, axi.awready, axi.wready, ap_start, interrupt, dcr_wr_valid},
              8'd0);
        tick();
        tick();
        ap_rst_n   = 1'b1;
        axi.rready = 1'b1;
        repeat (4) tick();
        @(negedge ap_clk);
        check("post_reset_quiet", {axi.rvalid, axi.bvalid, axi.awready, axi.wready, axi.arready}, 5'b00111);
        tick();
        axi_read("gie_after_reset", 8'h04, 32'h0, RESP_OKAY);
        axi_read("ctrl_after_reset", 8'h00, 32'h4, RESP_OKAY);
        axi_read("dcr_addr_after_reset", 8'h18, 32'h0, RESP_OKAY);

        repeat (3) tick();
        check("queues_drained", exp_b.size() + exp_r.size() + exp_dcr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
